// File: rtl/coder_ctrl.sv
// Command sequencer for the coder datapath: FIFO-buffered ops, one-cycle issue pulses, fixed busy timing.
// Optional busy/command performance counters are built when CODER_CTRL_PERF_EN is defined.
module coder_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  output logic              coder_active,
  output logic [3:0]        coder_mode,
  output logic              coder_load_enc,
  output logic              coder_load_dec,
  output logic              ram_owner,
  output logic              busy,
  output logic              done,
  output logic [3:0]        done_op,
  output logic              err_illegal,
  output logic [PERF_W-1:0] perf_busy_cycles,
  output logic [15:0]       perf_cmd_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RUN, S_LOAD, S_DONE} state_e;

  function automatic logic [6:0] work_cycles(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: work_cycles = 7'd66;
      4'd3, 4'd6: work_cycles = 7'd63;
      4'd4, 4'd8: work_cycles = 7'd33;
      4'd5:       work_cycles = 7'd99;
      4'd7:       work_cycles = 7'd97;
      default:    work_cycles = 7'd0;
    endcase
  endfunction

  logic [3:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, empty, push, pop;
  logic [3:0]       head;

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [6:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = fifo_mem[rd_ptr_q];

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    err_d          = 1'b0;
    pop            = 1'b0;
    coder_active   = 1'b0;
    coder_mode     = 4'd0;
    coder_load_enc = 1'b0;
    coder_load_dec = 1'b0;
    ram_owner      = 1'b0;
    done           = 1'b0;
    done_op        = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head >= 4'd1 && head <= 4'd8) begin
            op_d    = head;
            state_d = S_ISSUE;
          end else if (head == 4'd9 || head == 4'd10) begin
            op_d    = head;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        coder_active = 1'b1;
        coder_mode   = op_q;
        ram_owner    = 1'b1;
        cnt_d        = work_cycles(op_q);
        state_d      = S_RUN;
      end
      S_RUN: begin
        coder_mode = op_q;
        ram_owner  = 1'b1;
        cnt_d      = cnt_q - 7'd1;
        if (cnt_q == 7'd1) state_d = S_DONE;
      end
      S_LOAD: begin
        coder_load_enc = (op_q == 4'd9);
        coder_load_dec = (op_q == 4'd10);
        state_d        = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        done_op = op_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign err_illegal = err_q;

`ifdef CODER_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_busy_q;
  logic [15:0]       perf_cmd_q;

  // Busy counter sticks at all-ones; command counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_q <= '0;
      perf_cmd_q  <= '0;
    end else begin
      if (ram_owner && perf_busy_q != '1) perf_busy_q <= perf_busy_q + PERF_W'(1);
      if (done) perf_cmd_q <= perf_cmd_q + 16'd1;
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_cmd_count   = perf_cmd_q;
`else
  assign perf_busy_cycles = '0;
  assign perf_cmd_count   = '0;
`endif

endmodule

// File: tb/tb_coder_ctrl.sv
// Self-checking bench for coder_ctrl: directed timing scenarios plus random traffic against a timeline model.
module tb_coder_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_op = 4'd0;
  logic        cmd_ready, coder_active, coder_load_enc, coder_load_dec;
  logic        ram_owner, busy, done, err_illegal;
  logic [3:0]  coder_mode, done_op;
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_cmd_count;

  coder_ctrl #(.FIFO_DEPTH(DEPTH), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .coder_active(coder_active), .coder_mode(coder_mode), .coder_load_enc(coder_load_enc),
    .coder_load_dec(coder_load_dec), .ram_owner(ram_owner), .busy(busy), .done(done),
    .done_op(done_op), .err_illegal(err_illegal), .perf_busy_cycles(perf_busy_cycles),
    .perf_cmd_count(perf_cmd_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pending commands as a queue; the running command as (op, start cycle).
  int wtab [16] = '{0, 66, 66, 63, 33, 99, 63, 97, 33, 0, 0, 0, 0, 0, 0, 0};
  int q[$];
  int cur_op = 0, t0 = 0, cyc = 0;
  bit act_cmd = 0, err_exp = 0;
  longint pb = 0;
  int pc = 0;
  int act_log[$], done_log[$], le_log[$];
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int last_k(input int op);
    return (op <= 8) ? wtab[op] + 1 : 1;
  endfunction

  function automatic bit on_now();
    return act_cmd && (cyc >= t0) && (cyc - t0 <= last_k(cur_op));
  endfunction

  task automatic model_edge();
    bit pre_on, rdy;
    int k;
    pre_on = on_now();
    k = cyc - t0;
    if (rst) begin
      q.delete();
      act_cmd = 0;
      err_exp = 0;
      pb = 0;
      pc = 0;
      cyc++;
      return;
    end
    if (pre_on && cur_op <= 8 && k <= wtab[cur_op]) pb++;
    if (pre_on && k == last_k(cur_op)) pc = (pc + 1) & 16'hffff;
    rdy = (q.size() < DEPTH);
    err_exp = 0;
    if (!pre_on && q.size() > 0) begin
      int op;
      op = q.pop_front();
      if (op >= 1 && op <= 10) begin
        cur_op = op;
        t0 = cyc + 1;
        act_cmd = 1;
      end else begin
        act_cmd = 0;
        err_exp = 1;
      end
    end
    if (cmd_valid && rdy) q.push_back(int'(cmd_op));
    cyc++;
  endtask

  task automatic check_all();
    bit on, run;
    int k;
    on = on_now();
    k = cyc - t0;
    run = on && cur_op <= 8;
    chk("cmd_ready", cmd_ready, q.size() < DEPTH);
    chk("coder_active", coder_active, run && k == 0);
    chk("coder_mode", coder_mode, (run && k <= wtab[cur_op]) ? cur_op : 0);
    chk("ram_owner", ram_owner, run && k <= wtab[cur_op]);
    chk("load_enc", coder_load_enc, on && cur_op == 9 && k == 0);
    chk("load_dec", coder_load_dec, on && cur_op == 10 && k == 0);
    chk("busy", busy, on);
    chk("done", done, on && k == last_k(cur_op));
    chk("done_op", done_op, (on && k == last_k(cur_op)) ? cur_op : 0);
    chk("err_illegal", err_illegal, err_exp);
`ifdef CODER_CTRL_PERF_EN
    chk("perf_busy", perf_busy_cycles, pb[31:0]);
    chk("perf_cmd", perf_cmd_count, pc);
`else
    chk("perf_busy", perf_busy_cycles, 0);
    chk("perf_cmd", perf_cmd_count, 0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    if (coder_active) act_log.push_back(cyc);
    if (done) done_log.push_back(cyc);
    if (coder_load_enc) le_log.push_back(cyc);
    if (err_illegal) err_cnt++;
  endtask

  task automatic clear_logs();
    act_log.delete();
    done_log.delete();
    le_log.delete();
    err_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic push(input int op);
    cmd_valid = 1'b1;
    cmd_op = 4'(op);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((on_now() || q.size() > 0) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 0, 1);
    step();
    step();
  endtask

  function automatic int at(input int lg[$], input int i);
    return (lg.size() > i) ? lg[i] : -100000;
  endfunction

  initial begin
    int base, pushes, n;
    bit saw_full;

    // Reset state and single op 4.
    do_reset();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    push(4);
    base = cyc;
    wait_idle();
    chk("t1_active", at(act_log, 0) - base, 1);
    chk("t1_done", at(done_log, 0) - base, 35);

    // LOAD_ENC followed by op 3.
    do_reset();
    push(9);
    base = cyc;
    push(3);
    wait_idle();
    chk("t2_load_enc", at(le_log, 0) - base, 1);
    chk("t2_done9", at(done_log, 0) - base, 2);
    chk("t2_active3", at(act_log, 0) - base, 4);
    chk("t2_done3", at(done_log, 1) - base, 68);

    // Six op-5 commands with valid held: fills FIFO, back-pressure, fixed spacing.
    do_reset();
    cmd_op = 4'd5;
    cmd_valid = 1'b1;
    pushes = 0;
    n = 0;
    saw_full = 0;
    while (pushes < 6 && n < 2000) begin
      bit r;
      r = cmd_ready;
      if (!r) saw_full = 1;
      step();
      if (r) pushes++;
      n++;
    end
    cmd_valid = 1'b0;
    wait_idle();
    chk("t3_full_seen", saw_full, 1);
    chk("t3_issued", act_log.size(), 6);
    for (int i = 1; i < 6; i++) chk("t3_spacing", at(act_log, i) - at(act_log, i - 1), 102);

    // Illegal ops dropped, then op 8.
    do_reset();
    push(0);
    push(12);
    push(8);
    wait_idle();
    chk("t4_err_count", err_cnt, 2);
    chk("t4_done_count", done_log.size(), 1);
    chk("t4_latency", at(done_log, 0) - at(act_log, 0), 34);

    // Reset during RUN of op 7.
    do_reset();
    push(7);
    base = cyc;
    while (cyc - base < 50) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_ram_owner", ram_owner, 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_no_done", done_log.size(), 0);
    clear_logs();
    push(4);
    base = cyc;
    wait_idle();
    chk("t5_after_done", at(done_log, 0) - base, 35);

    // Performance counters after ops 1 and 8.
    do_reset();
    push(1);
    push(8);
    wait_idle();
`ifdef CODER_CTRL_PERF_EN
    chk("t6_perf_busy", perf_busy_cycles, 101);
    chk("t6_perf_cmd", perf_cmd_count, 2);
`else
    chk("t6_perf_busy", perf_busy_cycles, 0);
    chk("t6_perf_cmd", perf_cmd_count, 0);
`endif

    // Random traffic including illegal ops.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int r;
      cmd_valid = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      if (r < 2) cmd_op = 4'($urandom_range(0, 15));
      else if (r < 4) cmd_op = 4'd4;
      else if (r < 6) cmd_op = 4'd8;
      else if (r == 6) cmd_op = 4'd9;
      else if (r == 7) cmd_op = 4'd10;
      else cmd_op = 4'($urandom_range(1, 8));
      step();
    end
    cmd_valid = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
